// File: rtl/qspi_mem_responder.sv
// QSPI memory target emulated with an internal byte array, oversampling sck/cs_n on clk_i.
// Define QSPI_MEM_RESPONDER_ROM_EN to turn quad writes into ignored commands (ROM mode).
module qspi_mem_responder #(
    parameter int         DEPTH     = 4096,
    parameter int         DUMMY_CYC = 4,
    parameter logic [7:0] CMD_READ  = 8'hEB,
    parameter logic [7:0] CMD_WRITE = 8'h38
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cs_in,
    input  logic                     sck_i,
    input  logic [3:0]               sd_i,
    output logic [3:0]               sd_o,
    output logic [3:0]               sd_oen_o,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
    input  logic [7:0]               bd_data_i,
    output logic                     busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    // cs/sck/sd all see exactly two flops so sampled nibbles line up with the sck edge.
    // cs resets to "low" so a transaction needs cs seen high before a falling edge counts.
    logic [1:0] cs_sync_reg, sck_sync_reg;
    logic [3:0] sd_s;
    logic       cs_s, cs_d_reg, sck_s, sck_d_reg;
    logic       cs_fall, sck_rise, sck_fall;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sd_sync
            logic [1:0] lane_sync_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) lane_sync_reg <= 2'b00;
                else       lane_sync_reg <= {lane_sync_reg[0], sd_i[gi]};
            end
            assign sd_s[gi] = lane_sync_reg[1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_reg  <= 2'b00;
            sck_sync_reg <= 2'b00;
            cs_d_reg     <= 1'b0;
            sck_d_reg    <= 1'b0;
        end else begin
            cs_sync_reg  <= {cs_sync_reg[0], cs_in};
            sck_sync_reg <= {sck_sync_reg[0], sck_i};
            cs_d_reg     <= cs_s;
            sck_d_reg    <= sck_s;
        end
    end

    assign cs_s     = cs_sync_reg[1];
    assign sck_s    = sck_sync_reg[1];
    assign cs_fall  = cs_d_reg & ~cs_s;
    assign sck_rise = sck_s & ~sck_d_reg;
    assign sck_fall = sck_d_reg & ~sck_s;

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [23:0]   shift_reg, shift_next, shifted;
    logic          is_write_reg, is_write_next;
    logic          phase_reg, phase_next;
    logic [3:0]    hi_nib_reg, hi_nib_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [3:0]    sd_o_reg, sd_o_next, oen_reg, oen_next;
    logic          busy_reg, busy_next;
    logic          wr_en_reg, wr_en_next;
    logic [7:0]    wr_byte_reg, wr_byte_next;
    logic [7:0]    rd_data_reg;

    logic [7:0]    mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // Protocol writes take the port first; backdoor only ever writes while idle.
    assign mem_we    = wr_en_reg | (bd_we_i && state_reg == S_IDLE);
    assign mem_waddr = wr_en_reg ? addr_reg : bd_addr_i;
    assign mem_wdata = wr_en_reg ? wr_byte_reg : bd_data_i;

    // The read port follows addr continuously, so a byte is ready long before its first falling edge.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data_reg <= mem[addr_reg];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            is_write_reg <= 1'b0;
            phase_reg    <= 1'b0;
            hi_nib_reg   <= '0;
            addr_reg     <= '0;
            sd_o_reg     <= '0;
            oen_reg      <= '0;
            busy_reg     <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_byte_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            is_write_reg <= is_write_next;
            phase_reg    <= phase_next;
            hi_nib_reg   <= hi_nib_next;
            addr_reg     <= addr_next;
            sd_o_reg     <= sd_o_next;
            oen_reg      <= oen_next;
            busy_reg     <= busy_next;
            wr_en_reg    <= wr_en_next;
            wr_byte_reg  <= wr_byte_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        shifted       = {shift_reg[19:0], sd_s};
        is_write_next = is_write_reg;
        phase_next    = phase_reg;
        hi_nib_next   = hi_nib_reg;
        addr_next     = addr_reg;
        sd_o_next     = sd_o_reg;
        oen_next      = oen_reg;
        wr_en_next    = 1'b0;
        wr_byte_next  = wr_byte_reg;

        if (wr_en_reg) addr_next = addr_reg + 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (cs_fall) begin
                    state_next = S_CMD;
                    cnt_next   = '0;
                    addr_next  = '0;
                    phase_next = 1'b0;
                end
            end
            S_CMD: begin
                if (sck_rise) begin
                    shift_next = shifted;
                    cnt_next   = cnt_reg + 8'd1;
                    if (cnt_reg == 8'd1) begin
                        cnt_next = '0;
                        if (shifted[7:0] == CMD_READ) begin
                            is_write_next = 1'b0;
                            state_next    = S_ADDR;
                        end else if (shifted[7:0] == CMD_WRITE) begin
`ifdef QSPI_MEM_RESPONDER_ROM_EN
                            state_next    = S_IGNORE;
`else
                            is_write_next = 1'b1;
                            state_next    = S_ADDR;
`endif
                        end else begin
                            state_next = S_IGNORE;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise) begin
                    shift_next = shifted;
                    cnt_next   = cnt_reg + 8'd1;
                    if (cnt_reg == 8'd5) begin
                        cnt_next   = '0;
                        addr_next  = shifted[AW-1:0];
                        phase_next = 1'b0;
                        if (is_write_reg)        state_next = S_WDATA;
                        else if (DUMMY_CYC == 0) state_next = S_RDATA;
                        else                     state_next = S_DUMMY;
                    end
                end
            end
            S_DUMMY: begin
                if (sck_rise) cnt_next = cnt_reg + 8'd1;
                if (sck_fall && cnt_reg == DUMMY_N) begin
                    sd_o_next  = rd_data_reg[7:4];
                    oen_next   = 4'hF;
                    phase_next = 1'b1;
                    state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (sck_fall) begin
                    oen_next = 4'hF;
                    if (!phase_reg) begin
                        sd_o_next  = rd_data_reg[7:4];
                        phase_next = 1'b1;
                    end else begin
                        sd_o_next  = rd_data_reg[3:0];
                        addr_next  = addr_reg + 1'b1;
                        phase_next = 1'b0;
                    end
                end
            end
            S_WDATA: begin
                if (sck_rise) begin
                    if (!phase_reg) begin
                        hi_nib_next = sd_s;
                        phase_next  = 1'b1;
                    end else begin
                        wr_en_next   = 1'b1;
                        wr_byte_next = {hi_nib_reg, sd_s};
                        phase_next   = 1'b0;
                    end
                end
            end
            S_IGNORE: oen_next = 4'h0;
            default:  state_next = S_IDLE;
        endcase

        // cs_n high aborts everything; a lone buffered high nibble is simply forgotten.
        if (state_reg != S_IDLE && cs_s) begin
            state_next = S_IDLE;
            oen_next   = 4'h0;
            phase_next = 1'b0;
        end

        busy_next = (state_next != S_IDLE);
    end

    assign sd_o     = sd_o_reg;
    assign sd_oen_o = oen_reg;
    assign busy_o   = busy_reg;
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: backdoor preload, quad read/write, wrap, abort and reset.
module tb_qspi_mem_responder;
    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [3:0]  sd_in = 4'h0;
    logic [3:0]  sd_out;
    logic [3:0]  sd_oen;
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    qspi_mem_responder dut (
        .clk_i(clk), .rst_i(rst), .cs_in(cs_n), .sck_i(sck), .sd_i(sd_in),
        .sd_o(sd_out), .sd_oen_o(sd_oen), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
        .bd_data_i(bd_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic backdoor(input logic [11:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        #10;
        bd_we = 1'b0;
        #10;
    endtask

    // One sck period ending on the falling edge; data is set up during the low phase.
    task automatic sck_cycle(input logic [3:0] n);
        sd_in = n;
        #HALF; sck = 1'b1;
        #HALF; sck = 1'b0;
    endtask

    task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        cs_n = 1'b0;
        #HALF;
        sck_cycle(cmd[7:4]);
        sck_cycle(cmd[3:0]);
        for (int i = 0; i < 6; i++) sck_cycle(a[23-4*i -: 4]);
    endtask

    task automatic end_xfer(input string tag);
        #40; cs_n = 1'b1;
        #100;
        chk({7'd0, busy}, 8'h00, {tag, "_busy_end"});
        chk({4'd0, sd_oen}, 8'h00, {tag, "_oen_end"});
    endtask

    task automatic qspi_read(input logic [23:0] a, input int nn, input logic [31:0] exp, input string tag);
        cmd_addr(8'hEB, a);
        #40;
        chk({4'd0, sd_oen}, 8'h00, {tag, "_oen_addr"});
        chk({7'd0, busy}, 8'h01, {tag, "_busy"});
        for (int d = 0; d < 4; d++) begin
            sck_cycle(4'h0);
            if (d < 3) begin
                #40;
                chk({4'd0, sd_oen}, 8'h00, {tag, "_oen_dummy"});
            end
        end
        for (int k = 0; k < nn; k++) begin
            #40;
            chk({4'd0, sd_oen}, 8'h0F, $sformatf("%s_oen_d%0d", tag, k));
            chk({4'd0, sd_out}, {4'd0, exp[4*(nn-1-k) +: 4]}, $sformatf("%s_nib%0d", tag, k));
            if (k < nn - 1) sck_cycle(4'h0);
        end
        end_xfer(tag);
    endtask

    task automatic qspi_write(input logic [23:0] a, input int nn, input logic [31:0] d);
        cmd_addr(8'h38, a);
        for (int k = 0; k < nn; k++) sck_cycle(d[4*(nn-1-k) +: 4]);
        #40; cs_n = 1'b1;
        #100;
    endtask

    initial begin
        #30;
        chk({4'd0, sd_out}, 8'h00, "rst_sd_o");
        chk({4'd0, sd_oen}, 8'h00, "rst_oen");
        chk({7'd0, busy}, 8'h00, "rst_busy");
        rst = 1'b0;
        #50;

        backdoor(12'h000, 8'hA5);
        backdoor(12'h001, 8'h3C);
        qspi_read(24'h000000, 4, 32'h0000A53C, "rd0");

        backdoor(12'h010, 8'h5E);
        backdoor(12'h011, 8'h6F);
        qspi_write(24'h000010, 4, 32'h00001234);
`ifdef QSPI_MEM_RESPONDER_ROM_EN
        qspi_read(24'h000010, 4, 32'h00005E6F, "rd10");
`else
        qspi_read(24'h000010, 4, 32'h00001234, "rd10");
`endif

        backdoor(12'hFFF, 8'hFF);
        backdoor(12'h000, 8'h01);
        qspi_read(24'h000FFF, 4, 32'h0000FF01, "wrap");

        // Unknown command: lanes never driven, busy released within 4 clk_i of cs_n rising.
        cs_n = 1'b0;
        #HALF;
        sck_cycle(4'h9);
        sck_cycle(4'hF);
        for (int i = 0; i < 10; i++) begin
            sck_cycle(4'h0);
            #40;
            chk({4'd0, sd_oen}, 8'h00, $sformatf("ign_oen%0d", i));
        end
        chk({7'd0, busy}, 8'h01, "ign_busy");
        cs_n = 1'b1;
        #40;
        chk({7'd0, busy}, 8'h00, "ign_busy_drop");
        #100;

        backdoor(12'h020, 8'h99);
        backdoor(12'h021, 8'hC7);
        qspi_write(24'h000020, 3, 32'h00000AB5);
`ifdef QSPI_MEM_RESPONDER_ROM_EN
        qspi_read(24'h000020, 4, 32'h000099C7, "part");
`else
        qspi_read(24'h000020, 4, 32'h0000ABC7, "part");
`endif

        // Reset in the middle of a read releases the lanes on the next clock.
        cmd_addr(8'hEB, 24'h000000);
        for (int d = 0; d < 4; d++) sck_cycle(4'h0);
        #40;
        chk({4'd0, sd_oen}, 8'h0F, "mid_oen");
        rst = 1'b1;
        #10;
        chk({4'd0, sd_oen}, 8'h00, "rst_mid_oen");
        chk({7'd0, busy}, 8'h00, "rst_mid_busy");
        #10;
        rst = 1'b0;
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        #40;
        chk({7'd0, busy}, 8'h00, "rst_no_restart");
        chk({4'd0, sd_oen}, 8'h00, "rst_no_drive");
        cs_n = 1'b1;
        #100;

        qspi_write(24'h000000, 2, 32'h00000077);
`ifdef QSPI_MEM_RESPONDER_ROM_EN
        qspi_read(24'h000000, 2, 32'h00000001, "rom");
`else
        qspi_read(24'h000000, 2, 32'h00000077, "sram");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI memory responder: the target side of the ExoTiny QSPI memory interface (cs_n, sck, sd[3:0]).
- Uses an internal byte array to emulate an external QSPI SRAM/ROM. Used for on-FPGA self-test and as the simulation memory model behind the SoC's mem_* pins.
- Oversamples sck/cs_n using the system clock; no logic is clocked by sck.

Parameters:
DEPTH, 4096, backing-store size in bytes; power of two; address wraps modulo DEPTH.
DUMMY_CYC, 4, sck cycles between the last address nibble and the first read data nibble.
CMD_READ, 8'hEB, quad read command.
CMD_WRITE, 8'h38, quad write command.

Ports:
clk_i  in  1  system clock; must be >= 8x sck frequency.
rst_i  in  1  synchronous, active-high reset.
cs_in  in  1  chip select from the initiator, active low, asynchronous to clk_i.
sck_i  in  1  QSPI clock, SPI mode 0, asynchronous.
sd_i  in  4  QSPI data from the initiator.
sd_o  out  4  QSPI data to the initiator.
sd_oen_o  out  4  per-lane output enable, 1 = drive.
bd_we_i  in  1  backdoor write strobe (preload); sampled only while state is IDLE.
bd_addr_i  in  $clog2(DEPTH)  backdoor byte address.
bd_data_i  in  8  backdoor byte.
busy_o  out  1  high from cs_n falling edge until return to IDLE.

Behaviour:
- Synchronization:
  - cs_in, sck_i and sd_i pass through 2-FF synchronizers with equal delay.
  - Edges are detected on the synchronized sck and cs_n.
- Reset values: sd_o=0, sd_oen_o=0, busy_o=0, state=IDLE, address/shift counters=0. The array contents are not reset.
- Lane usage: all fields are quad (4 lanes), most-significant nibble first.
  - Command: 2 nibbles.
  - Address: 6 nibbles (24 bit; upper bits above $clog2(DEPTH) are ignored).
  - Data: 2 nibbles per byte.
- Sample and drive edges:
  - Input nibbles are sampled at the detected sck rising edge.
  - Outputs update at the detected sck falling edge, within 4 clk_i cycles of the pin edge.
- States:
  - IDLE: cs_n falling -> CMD, busy_o=1.
  - CMD: after 2 nibbles:
    - CMD_READ -> ADDR (read)
    - CMD_WRITE -> ADDR (write)
    - anything else -> IGNORE
  - ADDR: after 6 nibbles -> DUMMY (read) or WDATA (write). If DUMMY_CYC=0, a read goes straight to RDATA.
  - DUMMY: count DUMMY_CYC rising edges. Issue the array read at addr during DUMMY (1-cycle synchronous read). At the last falling edge: drive the high nibble, sd_oen_o=4'hF -> RDATA.
  - RDATA: each falling edge shifts out the next nibble. After the low nibble is driven: addr+1, prefetch the next byte. Continues indefinitely until cs_n rises.
  - WDATA: each pair of sampled nibbles forms a byte written to array[addr] on the cycle after the 2nd nibble, then addr+1.
  - IGNORE: sd_oen_o=0; wait for cs_n high.
- cs_n rising in any state: on the next clk_i go to IDLE, sd_oen_o=0, busy_o=0. A partially received write byte (1 nibble) is discarded. The address is not retained across transactions.
- Wrap: addr=DEPTH-1 increments to 0 for both read and write.
- Backdoor: bd_we_i while state==IDLE writes array[bd_addr_i]=bd_data_i. It is ignored in any other state.
- Backdoor and cs_n falling in the same cycle: the backdoor write completes, and the transaction still starts.
- rst_i mid-transaction: immediate return to IDLE, outputs released. A new transaction starts only after cs_n is seen high, then falling.

Optional Feature:
- Macro QSPI_MEM_RESPONDER_ROM_EN.
- Defined: ROM mode. CMD_WRITE goes to IGNORE (no array writes, no drive). The backdoor remains the only write path.
- Undefined: full read/write SRAM behaviour as above.

Test Plan:
- Backdoor-load 0x000=8'hA5, 0x001=8'h3C. Read EB, addr 0x000000, 4 dummy, 4 data nibbles -> sd_o sequence A,5,3,C; sd_oen_o=4'hF only during data nibbles.
- Write 38, addr 0x000010, bytes 8'h12,8'h34. Then read EB at 0x000010 -> 1,2,3,4.
- Wrap: backdoor DEPTH-1=8'hFF, 0=8'h01. Read from DEPTH-1 for 2 bytes -> F,F,0,1.
- Unknown command 8'h9F -> sd_oen_o stays 0 for the whole transaction; busy_o drops within 4 clk_i of cs_n rising.
- Write 38 at 0x20 with 3 nibbles (1.5 bytes: 8'hAB, then nibble 5), then cs_n high -> read back 0x20=AB, 0x21 unchanged. rst_i pulsed mid-read -> sd_oen_o=0 next cycle.
- With QSPI_MEM_RESPONDER_ROM_EN defined: write 38 at 0x0 of 8'h77 -> read returns the preloaded value, not 77.
